// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one picoMIPS ALU between two requesters.
// Operands are driven from registers; the response is returned over valid/ready.
module alu_arbiter #(
  parameter int         N        = 8,
  parameter logic [2:0] MUL_FUNC = 3'b110
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_func,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_func,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_func,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, RESP} state_t;

  state_t       state_reg, state_next;
  logic         ptr_reg, ptr_next;
  logic [N-1:0] a_reg, a_next;
  logic [N-1:0] b_reg, b_next;
  logic [2:0]   func_reg, func_next;
  logic [N-1:0] result_reg, result_next;
  logic [3:0]   flags_reg, flags_next;
  logic         id_reg, id_next;
  logic         grant0, grant1;

  // ptr_reg names the requester that wins when both are valid
  assign grant0     = req0_valid & (~req1_valid | ~ptr_reg);
  assign grant1     = req1_valid & (~req0_valid |  ptr_reg);
  assign req0_ready = (state_reg == IDLE) & grant0;
  assign req1_ready = (state_reg == IDLE) & grant1;

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_func   = func_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign rsp_flags  = flags_reg;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      func_reg   <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      id_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      func_reg   <= func_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      id_reg     <= id_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    func_next   = func_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    id_next     = id_reg;
    case (state_reg)
      IDLE: begin
        if (req0_ready) begin
          a_next     = req0_a;
          b_next     = req0_b;
          func_next  = req0_func;
          id_next    = 1'b0;
          ptr_next   = 1'b1;
          state_next = EXEC;
        end else if (req1_ready) begin
          a_next     = req1_a;
          b_next     = req1_b;
          func_next  = req1_func;
          id_next    = 1'b1;
          ptr_next   = 1'b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // the multiplier output is registered inside the ALU, so wait a cycle
        if (func_reg == MUL_FUNC) begin
          state_next = MULW;
        end else begin
          result_next = alu_result;
          flags_next  = alu_flags;
          state_next  = RESP;
        end
      end
      MULW: begin
        result_next = alu_result;
        flags_next  = alu_flags;
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stub (registered multiplier) plus
// directed scenarios and a randomized run against a transaction-level model.
module tb_alu_arbiter;
  localparam int N = 8;
  localparam logic [2:0] RA = 3'd0, RADD = 3'd1, RSUB = 3'd2, RAND = 3'd3,
                         ROR = 3'd4, RXOR = 3'd5, RMUL = 3'd6, RNOR = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_func = '0, req1_func = '0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_func;
  logic [3:0]   alu_flags;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [3:0]   mul_reg;
  logic [11:0]  alu_fr;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.N(N), .MUL_FUNC(RMUL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics: returns {V,N,Z,C, result}; C on subtract is borrow.
  function automatic logic [11:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       v, c;
    v = 1'b0; c = 1'b0; r = '0; w = '0;
    case (f)
      RA:   r = a;
      RADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      RSUB: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      RAND: r = a & b;
      ROR:  r = a | b;
      RXOR: r = a ^ b;
      RMUL: r = {4'b0000, a[3:0] * b[3:0]};
      RNOR: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  // ALU stub: combinational except multiply, whose product is registered.
  always @(posedge clk) mul_reg <= alu_a[3:0] * alu_b[3:0];
  always_comb begin
    alu_fr = alu_ref(alu_func, alu_a, alu_b);
    if (alu_func == RMUL) alu_fr = {2'b00, (mul_reg == 4'h0), 1'b0, 4'h0, mul_reg};
  end
  assign alu_result = alu_fr[7:0];
  assign alu_flags  = alu_fr[11:8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {rsp_valid, busy, req0_ready, req1_ready, rsp_id}); end
    checks++;
    if ({alu_func, alu_a, alu_b, rsp_flags, rsp_result} !== 31'h0)
      begin errors++; $display("FAIL reset_data got=%h exp=0", {alu_func, alu_a, alu_b, rsp_flags, rsp_result}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    req0_valid = 1; req0_func = RADD; req0_a = 8'h05; req0_b = 8'h03; rsp_ready = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100)
      begin errors++; $display("FAIL add_grant got=%b exp=100", {req0_ready, req1_ready, busy}); end
    @(negedge clk); req0_valid = 0; #1;
    checks++;
    if ({req0_ready, busy, rsp_valid} !== 3'b010)
      begin errors++; $display("FAIL add_exec got=%b exp=010", {req0_ready, busy, rsp_valid}); end
    checks++;
    if ({alu_func, alu_a, alu_b} !== {RADD, 8'h05, 8'h03})
      begin errors++; $display("FAIL add_alu_in got=%h exp=%h", {alu_func, alu_a, alu_b}, {RADD, 8'h05, 8'h03}); end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency rsp_valid=%b exp=1", rsp_valid); end
    checks++;
    if ({rsp_id, rsp_flags, rsp_result} !== {1'b0, 4'b0000, 8'h08})
      begin errors++; $display("FAIL add_rsp got id=%0d f=%b r=%h exp id=0 f=0000 r=08", rsp_id, rsp_flags, rsp_result); end
    $display("txn add id=%0d r=%h f=%b", rsp_id, rsp_result, rsp_flags);
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0; #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_release got=%b exp=00", {rsp_valid, busy}); end
  endtask

  task automatic test_mul_latency();
    @(negedge clk);
    req1_valid = 1; req1_func = RMUL; req1_a = 8'h03; req1_b = 8'h05; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL mul_grant got=%b exp=01", {req0_ready, req1_ready}); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); req1_valid = 0; #1;
      checks++;
      if ({rsp_valid, busy, alu_func} !== {1'b0, 1'b1, RMUL})
        begin errors++; $display("FAIL mul_wait%0d got v=%b busy=%b func=%0d exp v=0 busy=1 func=%0d", i, rsp_valid, busy, alu_func, RMUL); end
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 1'b1, 4'b0000, 8'h0F})
      begin errors++; $display("FAIL mul_rsp got v=%b id=%0d f=%b r=%h exp v=1 id=1 f=0000 r=0f", rsp_valid, rsp_id, rsp_flags, rsp_result); end
    $display("txn mul id=%0d r=%h f=%b", rsp_id, rsp_result, rsp_flags);
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

  task automatic test_contention();
    int ngrant = 0;
    int nrsp = 0;
    logic [12:0] exp_rsp;
    @(negedge clk);
    req0_valid = 1; req0_func = RSUB; req0_a = 8'h05; req0_b = 8'h05;
    req1_valid = 1; req1_func = RADD; req1_a = 8'h7F; req1_b = 8'h01;
    rsp_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (req0_ready || req1_ready) begin
        checks++;
        if ({req1_ready, req0_ready} !== ((ngrant % 2) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL contention_grant%0d got r1r0=%b", ngrant, {req1_ready, req0_ready}); end
        ngrant++;
      end
      if (rsp_valid) begin
        exp_rsp = (nrsp % 2) ? {1'b1, 4'b1100, 8'h80} : {1'b0, 4'b0010, 8'h00};
        checks++;
        if ({rsp_id, rsp_flags, rsp_result} !== exp_rsp)
          begin errors++; $display("FAIL contention_rsp%0d got=%h exp=%h", nrsp, {rsp_id, rsp_flags, rsp_result}, exp_rsp); end
        $display("txn contention id=%0d r=%h f=%b", rsp_id, rsp_result, rsp_flags);
        nrsp++;
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    checks++;
    if (ngrant != 4 || nrsp != 4)
      begin errors++; $display("FAIL contention_count got grants=%0d rsps=%0d exp 4/4", ngrant, nrsp); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req0_valid = 1; req0_func = RXOR; req0_a = 8'hA5; req0_b = 8'h0F; rsp_ready = 0; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant req0_ready=%b exp=1", req0_ready); end
    @(negedge clk);
    req0_func = RADD; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1; req1_func = ROR; req1_a = 8'h33; req1_b = 8'h44;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_flags, rsp_result, alu_func, alu_a, alu_b}
          !== {4'b1100, 1'b0, 4'b0100, 8'hAA, RXOR, 8'hA5, 8'h0F})
        begin errors++; $display("FAIL bp_hold%0d v=%b busy=%b rdy=%b%b id=%0d f=%b r=%h alu=%0d/%h/%h exp v=1 busy=1 rdy=00 id=0 f=0100 r=aa",
                                 i, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_flags, rsp_result, alu_func, alu_a, alu_b); end
    end
    $display("txn backpressure id=%0d r=%h f=%b", rsp_id, rsp_result, rsp_flags);
    @(negedge clk); rsp_ready = 1; #1;
    @(negedge clk); rsp_ready = 0; #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0001)
      begin errors++; $display("FAIL bp_release got v,busy,r0,r1=%b exp=0001", {rsp_valid, busy, req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req0_valid = 1; req0_func = RMUL; req0_a = 8'h03; req0_b = 8'h04; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant req0_ready=%b exp=1", req0_ready); end
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    rst_n = 0; #1;
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_flags, rsp_result, alu_func, alu_a, alu_b} !== 34'h0)
      begin errors++; $display("FAIL rmid_async got v=%b busy=%b id=%0d f=%b r=%h alu=%0d/%h/%h exp all 0",
                               rsp_valid, busy, rsp_id, rsp_flags, rsp_result, alu_func, alu_a, alu_b); end
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_func = RAND; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1; req1_func = RADD; req1_a = 8'h01; req1_b = 8'h01;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10)
      begin errors++; $display("FAIL rmid_ptr got r0r1=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_quiet%0d got v,busy=%b exp=00", i, {rsp_valid, busy}); end
    end
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    req0_valid = 1; req0_func = RADD; req0_a = 8'h10; req0_b = 8'h20; rsp_ready = 0; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL wd_grant got=%b exp=10", {req0_ready, req1_ready}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); req0_valid = 0; req1_valid = 1; req1_func = RSUB; req1_a = 8'h09; req1_b = 8'h01; #1;
      checks++;
      if ({req1_ready, busy} !== 2'b01) begin errors++; $display("FAIL wd_busy%0d got r1,busy=%b exp=01", i, {req1_ready, busy}); end
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 1'b0, 4'b0000, 8'h30})
      begin errors++; $display("FAIL wd_rsp got v=%b id=%0d f=%b r=%h exp v=1 id=0 f=0000 r=30", rsp_valid, rsp_id, rsp_flags, rsp_result); end
    $display("txn withdrawn id=%0d r=%h f=%b", rsp_id, rsp_result, rsp_flags);
    @(negedge clk); req1_valid = 0; rsp_ready = 1;
    @(negedge clk); rsp_ready = 0; #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0000)
      begin errors++; $display("FAIL wd_idle got=%b exp=0000", {rsp_valid, busy, req0_ready, req1_ready}); end
    @(negedge clk); req0_valid = 1; req1_valid = 1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL wd_ptr got r0r1=%b exp=01", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  // Transaction-level model: one outstanding op, fixed latency by function,
  // round-robin priority flips to the other requester after each grant.
  task automatic test_random();
    logic        outstanding = 0, m_ptr = 0, m_id = 0, g0, g1, exp_rv;
    logic [2:0]  m_f = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [11:0] m_fr;
    int          acc_cyc = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 99) < 55);
      req1_valid = ($urandom_range(0, 99) < 55);
      req0_func = 3'($urandom_range(0, 7)); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_func = 3'($urandom_range(0, 7)); req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 65);
      #1;
      exp_rv = outstanding && (c >= acc_cyc + ((m_f == RMUL) ? 3 : 2));
      g0 = !outstanding && req0_valid && (!req1_valid || !m_ptr);
      g1 = !outstanding && req1_valid && (!req0_valid || m_ptr);
      checks++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== {g0, g1, outstanding, exp_rv})
        begin errors++; $display("FAIL rnd_ctrl cyc=%0d got r0,r1,busy,v=%b exp=%b", c,
                                 {req0_ready, req1_ready, busy, rsp_valid}, {g0, g1, outstanding, exp_rv}); end
      checks++;
      if ({alu_func, alu_a, alu_b} !== {m_f, m_a, m_b})
        begin errors++; $display("FAIL rnd_alu_in cyc=%0d got=%h exp=%h", c, {alu_func, alu_a, alu_b}, {m_f, m_a, m_b}); end
      if (exp_rv) begin
        m_fr = alu_ref(m_f, m_a, m_b);
        checks++;
        if ({rsp_id, rsp_flags, rsp_result} !== {m_id, m_fr})
          begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", c, {rsp_id, rsp_flags, rsp_result}, {m_id, m_fr}); end
        if (rsp_ready)
          $display("txn rnd id=%0d func=%0d a=%h b=%h r=%h f=%b", rsp_id, m_f, m_a, m_b, rsp_result, rsp_flags);
      end
      if (g0 || g1) begin
        outstanding = 1; acc_cyc = c; m_id = g1; m_ptr = !g1;
        m_f = g1 ? req1_func : req0_func;
        m_a = g1 ? req1_a : req0_a;
        m_b = g1 ? req1_b : req0_b;
      end else if (exp_rv && rsp_ready) begin
        outstanding = 0;
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_mul_latency();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_withdrawn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single picoMIPS ALU (8 functions, including the registered 4x4 multiplier) between two requesters, e.g. the core datapath and a debug/peripheral port.
- Accepts one operation at a time over a valid/ready handshake, using round-robin arbitration.
- Drives the ALU operand and function inputs from registers, waits the correct latency (one extra cycle for multiply), then returns result, flags and requester ID over a valid/ready response channel.

Parameters:
- N, 8, operand/result width; must match the ALU width parameter.
- MUL_FUNC, RMUL code from the shared ALU code definitions, function code that takes the multiplier path with extra latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_func  in  3  ALU function code.
- req0_a, req0_b  in  N  operands.
- req1_valid, req1_ready, req1_func, req1_a, req1_b: same as requester 0.
- alu_a, alu_b  out  N  to ALU operands.
- alu_func  out  3  to ALU func.
- alu_result  in  N  from ALU result.
- alu_flags  in  4  from ALU flags {V,N,Z,C}.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  N  captured result.
- rsp_flags  out  4  captured flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - alu_a, alu_b, alu_func, rsp_result, rsp_flags, rsp_id and the round-robin pointer go to 0.
  - rsp_valid=0, busy=0.
  - Any in-flight operation is discarded with no response.
- States: IDLE, EXEC, MULW, RESP.
- IDLE:
  - reqX_ready is combinational: asserted only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - Grant rule: if exactly one valid is high, grant it. If both are high, grant the requester the pointer names.
  - On acceptance (valid & ready):
    - Latch func, a and b into alu_func/alu_a/alu_b.
    - Latch the ID.
    - Set the pointer to the other requester.
    - Go to EXEC.
  - With no valid, stay in IDLE and hold all registers.
- EXEC:
  - ALU inputs are stable from the registers.
  - If alu_func != MUL_FUNC: capture alu_result and alu_flags into rsp_result/rsp_flags at the end of this cycle, then go to RESP.
  - If alu_func == MUL_FUNC: go to MULW (multiplier output is registered inside the ALU and is valid one cycle later).
- MULW: capture alu_result and alu_flags, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held constant until rsp_ready=1.
  - On rsp_valid & rsp_ready, go to IDLE with rsp_valid=0 next cycle.
  - No new request is accepted in the handshake cycle.
- Latency from acceptance edge to rsp_valid: 2 cycles for non-multiply, 3 cycles for multiply.
- ALU inputs hold their last operation's values in IDLE and RESP; there are no spurious changes.
- Multiply result is the ALU's 4-bit product zero-extended. The arbiter forwards it unchanged and does not compute it.
- Unused ALU function codes are forwarded unchanged; the arbiter does not decode them apart from the MUL_FUNC comparison.
- A requester dropping valid before ready is legal: it is not granted and the pointer is unchanged.
- Reset asserted mid-operation returns the block to IDLE immediately; rsp_valid falls asynchronously.

Test Plan:
- Single add: req0 RADD a=8'h05 b=8'h03 -> req0_ready pulse 1 cycle; rsp_valid 2 cycles later; rsp_result=8'h08, rsp_flags=4'b0000, rsp_id=0.
- Multiply latency: req1 RMUL a=8'h03 b=8'h05 -> rsp_valid 3 cycles after acceptance; rsp_result=8'h0F, rsp_id=1; alu_func=RMUL stable through MULW.
- Contention: both valid continuously, req0 RSUB 8'h05-8'h05 and req1 RADD 8'h7F+8'h01, rsp_ready=1 -> grants alternate 0,1,0,1:
  - Responses: 8'h00 with Z=1 and C=0 for req0; 8'h80 with V=1 and N=1 for req1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* constant, busy=1, both reqX_ready=0; release -> IDLE next cycle.
- Reset mid-op: rst_n low while in MULW -> rsp_valid=0, busy=0, all outputs 0 immediately. After release, the next req0 is granted (pointer reset to 0).
- Withdrawn request: req1_valid high 0 cycles in IDLE (pulsed only while busy) -> never granted; pointer unchanged; no response with rsp_id=1.
